floating_multiplication: RTL and testbench

//  IEEE-754 binary32 multiplier for the NN datapath (neuron weight*input products).

---
 rtl/float_pkg.sv | 36 +++
 rtl/floating_multiplication_if.sv | 23 ++
 rtl/float_mul_round.sv | 54 +++++
 rtl/floating_multiplication.sv | 123 ++++++++++++
 tb/tb_floating_multiplication.sv | 115 +++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared binary32 definitions for the floating-point multiplier.
// Provides field widths, bias, special encodings, an unpacked field view and
// classification helpers. Subnormal encodings classify as zero (denormals-are-zero).
package float_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned FP_BIAS   = 127;

  localparam logic [31:0]         FP_QNAN    = 32'h7FC0_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  function automatic fp_t fp_unpack(input logic [31:0] x);
    return fp_t'(x);
  endfunction

  // Exponent field of zero covers both true zero and subnormals.
  function automatic logic fp_is_zero(input fp_t x);
    return x.exp == '0;
  endfunction

  function automatic logic fp_is_inf(input fp_t x);
    return (x.exp == FP_EXP_MAX) && (x.frac == '0);
  endfunction

  function automatic logic fp_is_nan(input fp_t x);
    return (x.exp == FP_EXP_MAX) && (x.frac != '0);
  endfunction

endpackage

// File: rtl/floating_multiplication_if.sv
// Operand/result bundle for the binary32 multiplier.
//   a, b    : operands driven by the master
//   result  : registered product driven by the slave
// With FLOAT_MUL_FLAGS_EN defined the bundle also carries the registered
// overflow, underflow and exception flags.
interface floating_multiplication_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
`ifdef FLOAT_MUL_FLAGS_EN
  logic overflow;
  logic underflow;
  logic exception;

  modport master (output a, b, input result, overflow, underflow, exception);
  modport slave  (input a, b, output result, overflow, underflow, exception);
`else
  modport master (output a, b, input result);
  modport slave  (input a, b, output result);
`endif
endinterface

// File: rtl/float_mul_round.sv
// Normalise and round-to-nearest-even a 48-bit significand product.
//   sign    : result sign, passed through
//   prod    : 24x24 significand product (hidden bits included), bit 47 or 46 leads
//   exp_in  : biased exponent eA+eB-bias before normalisation, 10-bit signed
//   res     : {sign, exp[7:0], frac} after normalise and round, not saturated
//   ovf     : final exponent >= 255, caller substitutes infinity
//   unf     : final exponent <= 0, caller substitutes signed zero
module float_mul_round (
  input  logic              sign,
  input  logic [47:0]       prod,
  input  logic signed [9:0] exp_in,
  output logic [31:0]       res,
  output logic              ovf,
  output logic              unf
);

  logic [22:0]       mant;
  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_n;
  logic signed [9:0] exp_f;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4): bit 47 set means >= 2.
    if (prod[47]) begin
      mant       = prod[46:24];
      guard_bit  = prod[23];
      round_bit  = prod[22];
      sticky_bit = |prod[21:0];
      exp_n      = exp_in + 10'sd1;
    end else begin
      mant       = prod[45:23];
      guard_bit  = prod[22];
      round_bit  = prod[21];
      sticky_bit = |prod[20:0];
      exp_n      = exp_in;
    end

    // Ties go to the even mantissa.
    round_up = guard_bit & (round_bit | sticky_bit | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};

    // All-ones mantissa rounding up wraps to zero; the value becomes 2.0 so bump exp.
    exp_f = exp_n + 10'(mant_r[23]);

    ovf = exp_f >= 10'sd255;
    unf = exp_f <= 10'sd0;
    res = {sign, exp_f[7:0], mant_r[22:0]};
  end

endmodule

// File: rtl/floating_multiplication.sv
// IEEE-754 binary32 multiplier with a single output register (latency 1,
// one product per clock). Round-to-nearest-even, subnormal inputs read as
// zero and subnormal results flush to signed zero.
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset, clears result (and flags)
//   bus   : floating_multiplication_if.slave, operands a/b in, result out
// Build option FLOAT_MUL_FLAGS_EN adds registered overflow, underflow and
// exception flags on the bus, aligned with result.
module floating_multiplication
  import float_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic                     clk,
  input logic                     rst,
  floating_multiplication_if.slave bus
);

  if (XLEN != 32) begin : gen_xlen_check
    $error("floating_multiplication: only XLEN=32 (binary32) is supported");
  end

  fp_t               op_a;
  fp_t               op_b;
  logic              sign;
  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;
  logic [47:0]       prod;
  logic signed [9:0] exp_sum;
  logic [31:0]       rnd_res;
  logic              rnd_ovf;
  logic              rnd_unf;
  logic [31:0]       result_d, result_q;

  assign op_a = fp_unpack(bus.a);
  assign op_b = fp_unpack(bus.b);

  assign a_zero = fp_is_zero(op_a);
  assign a_inf  = fp_is_inf(op_a);
  assign a_nan  = fp_is_nan(op_a);
  assign b_zero = fp_is_zero(op_b);
  assign b_inf  = fp_is_inf(op_b);
  assign b_nan  = fp_is_nan(op_b);

  assign sign = op_a.sign ^ op_b.sign;

  assign prod    = 48'({1'b1, op_a.frac}) * 48'({1'b1, op_b.frac});
  assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp})
                 - $signed(10'(FP_BIAS));

  float_mul_round u_round (
    .sign   (sign),
    .prod   (prod),
    .exp_in (exp_sum),
    .res    (rnd_res),
    .ovf    (rnd_ovf),
    .unf    (rnd_unf)
  );

  logic special_nan;
  logic special_inf;
  logic special_zero;

  assign special_nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign special_inf  = a_inf | b_inf;
  assign special_zero = a_zero | b_zero;

  // Priority: NaN / inf*0 > inf > zero > overflow > underflow > normal.
  always_comb begin
    result_d = rnd_res;
    if (special_nan) begin
      result_d = FP_QNAN;
    end else if (special_inf) begin
      result_d = {sign, FP_EXP_MAX, 23'h0};
    end else if (special_zero) begin
      result_d = {sign, 31'h0};
    end else if (rnd_ovf) begin
      result_d = {sign, FP_EXP_MAX, 23'h0};
    end else if (rnd_unf) begin
      result_d = {sign, 31'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

`ifdef FLOAT_MUL_FLAGS_EN
  logic finite_path;
  logic overflow_d, overflow_q;
  logic underflow_d, underflow_q;
  logic exception_d, exception_q;

  // Over/underflow only count when both operands were nonzero finite numbers.
  assign finite_path = ~special_nan & ~special_inf & ~special_zero;
  assign overflow_d  = finite_path & rnd_ovf;
  assign underflow_d = finite_path & ~rnd_ovf & rnd_unf;
  assign exception_d = a_nan | b_nan | a_inf | b_inf;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      exception_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      exception_q <= exception_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.exception = exception_q;
`endif

endmodule

// File: tb/tb_floating_multiplication.sv
// Scoreboard bench for floating_multiplication: the driver pushes the expected
// product for each operand pair, the monitor pops and compares one clock later.
module tb_floating_multiplication;

  logic clk = 1'b0;
  logic rst = 1'b1;

  floating_multiplication_if #(.XLEN(32)) bus ();

  floating_multiplication #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // flags = {overflow, underflow, exception}
  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  bit   inflight = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic issue(input logic rst_val, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [2:0] flags, input string name);
    exp_t e;
    @(negedge clk);
    rst   = rst_val;
    bus.a = a;
    bus.b = b;
    e.res   = res;
    e.flags = flags;
    e.name  = name;
    sb_q.push_back(e);
    inflight = 1'b1;
  endtask

  // Monitor: an operand pair applied before a rising edge is checked just after it.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (inflight) begin
        inflight = 1'b0;
        #1;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty got output with no expected entry");
        end else begin
          e = sb_q.pop_front();
          checks++;
          if (bus.result !== e.res) begin
            errors++;
            $display("FAIL %s result got %h want %h", e.name, bus.result, e.res);
          end
`ifdef FLOAT_MUL_FLAGS_EN
          checks++;
          if ({bus.overflow, bus.underflow, bus.exception} !== e.flags) begin
            errors++;
            $display("FAIL %s flags(ovf,unf,exc) got %b want %b", e.name,
                     {bus.overflow, bus.underflow, bus.exception}, e.flags);
          end
`endif
        end
      end
    end
  end

  initial begin : driver
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);

    // Reset dominates live operands; first product right after release.
    issue(1'b1, 32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 3'b000, "reset");
    issue(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000, "two_x_three");
    issue(1'b0, 32'h404C_CCCC, 32'h4086_6666, 32'h4157_0A3C, 3'b000, "rne_13_44");
    issue(1'b0, 32'hBF00_0000, 32'hC0CC_CCCC, 32'h404C_CCCC, 3'b000, "neg_x_neg");
    issue(1'b0, 32'hBF00_0000, 32'h40CC_CCCC, 32'hC04C_CCCC, 3'b000, "neg_x_pos");
    issue(1'b0, 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000, "tie_to_even");
    issue(1'b0, 32'h3F7F_FFFF, 32'h3F80_0001, 32'h3F80_0000, 3'b000, "round_down_norm");
    issue(1'b0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, "overflow");
    issue(1'b0, 32'h7F7F_FFFF, 32'h3F80_0001, 32'h7F80_0000, 3'b100, "overflow_after_norm");
    issue(1'b0, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 3'b000, "max_finite");
    issue(1'b0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b010, "underflow");
    issue(1'b0, 32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 3'b000, "min_normal");
    issue(1'b0, 32'h8000_0000, 32'h4049_0FDB, 32'h8000_0000, 3'b000, "neg_zero_x_pi");
    issue(1'b0, 32'h8000_0001, 32'h3F80_0000, 32'h8000_0000, 3'b000, "subnormal_daz");
    issue(1'b0, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b001, "inf_x_zero");
    issue(1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, "nan_in");
    issue(1'b0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b001, "neg_inf_x_two");
    issue(1'b0, 32'hFF80_0000, 32'hFFC0_0001, 32'h7FC0_0000, 3'b001, "neg_nan_canon");
    issue(1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, "reset_again");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending got %0d want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
